// File: rtl/l1_trigger_scheduler.sv
// l1_trigger_scheduler: pending Level-1 trigger register with in-order request/ack readout.
// Revision 1.0
`default_nettype none

module l1_trigger_scheduler #(
  parameter int DEPTH  = 16,
  parameter int BCID_W = 8,
  parameter int L1ID_W = 12
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     L1Trig_In,
  input  logic                     Bc_Reset,
  input  logic                     Ev_Reset,
  input  logic [7:0]               Latency,
  output logic                     L1_Reg_Full,
  output logic                     Trig_Lost,
  output logic [$clog2(DEPTH):0]   Pending_Count,
  output logic                     Rd_Req,
  output logic [BCID_W-1:0]        Rd_Bcid,
  output logic [L1ID_W-1:0]        Rd_L1id,
  input  logic                     Rd_Ack
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = BCID_W + L1ID_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_REQ  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [BCID_W-1:0]   r_bcid;
  logic [L1ID_W-1:0]   r_l1id;
  logic [EW-1:0]       r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       w_count_next;
  logic                r_full;
  logic                r_lost;
  logic [BCID_W-1:0]   r_rd_bcid;
  logic [L1ID_W-1:0]   r_rd_l1id;
  logic                w_push;
  logic                w_pop;
  logic                w_lost;
  logic [BCID_W-1:0]   w_trig_bcid;
  logic [BCID_W-1:0]   w_head_bcid;
  logic [L1ID_W-1:0]   w_head_l1id;

  // Ev_Reset wins over trigger and ack at the same edge: nothing is pushed, popped or lost.
  always_comb begin
    w_push       = L1Trig_In & ~r_full & ~Ev_Reset;
    w_lost       = L1Trig_In &  r_full & ~Ev_Reset;
    w_pop        = (r_state == S_REQ) & Rd_Ack & ~Ev_Reset;
    w_trig_bcid  = r_bcid - BCID_W'(Latency);
    {w_head_bcid, w_head_l1id} = r_mem[r_rd_ptr];
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (r_count != '0) w_state_next = S_LOAD;
      S_LOAD: w_state_next = S_REQ;
      S_REQ:  if (Rd_Ack) w_state_next = S_GAP;
      S_GAP:  w_state_next = (r_count != '0) ? S_LOAD : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (Ev_Reset) w_state_next = S_IDLE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_bcid    <= '0;
      r_l1id    <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_lost    <= 1'b0;
      r_rd_bcid <= '0;
      r_rd_l1id <= '0;
    end else begin
      r_state <= w_state_next;
      r_bcid  <= Bc_Reset ? '0 : r_bcid + BCID_W'(1);
      r_lost  <= w_lost;
      if (Ev_Reset) begin
        r_l1id   <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_full   <= 1'b0;
      end else begin
        r_count <= w_count_next;
        r_full  <= (w_count_next == CW'(DEPTH));
        if (w_push) begin
          r_l1id   <= r_l1id + L1ID_W'(1);
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (r_state == S_LOAD) begin
        r_rd_bcid <= w_head_bcid;
        r_rd_l1id <= w_head_l1id;
      end
    end
  end

  // Storage needs no reset; occupancy and pointers define which entries are valid.
  always_ff @(posedge Clk) begin
    if (!Reset && w_push) r_mem[r_wr_ptr] <= {w_trig_bcid, r_l1id};
  end

  assign L1_Reg_Full   = r_full;
  assign Trig_Lost     = r_lost;
  assign Pending_Count = r_count;
  assign Rd_Req        = (r_state == S_REQ);
  assign Rd_Bcid       = r_rd_bcid;
  assign Rd_L1id       = r_rd_l1id;

endmodule

`default_nettype wire

// File: tb/tb_l1_trigger_scheduler.sv
// tb_l1_trigger_scheduler: directed vector table plus hand sequences for l1_trigger_scheduler.
// Revision 1.0
`default_nettype none

module tb_l1_trigger_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic        bcr = 1'b0;
  logic        evr = 1'b0;
  logic [7:0]  lat = 8'd5;
  logic        ack = 1'b0;
  logic        full;
  logic        lost;
  logic [4:0]  cnt;
  logic        req;
  logic [7:0]  bcid;
  logic [11:0] l1id;

  int n_vec = 0;
  int n_err = 0;

  l1_trigger_scheduler #(.DEPTH(16), .BCID_W(8), .L1ID_W(12)) dut (
    .Clk(clk), .Reset(rst), .L1Trig_In(trig), .Bc_Reset(bcr), .Ev_Reset(evr),
    .Latency(lat), .L1_Reg_Full(full), .Trig_Lost(lost), .Pending_Count(cnt),
    .Rd_Req(req), .Rd_Bcid(bcid), .Rd_L1id(l1id), .Rd_Ack(ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic        rst, trig, ack, evr, bcr;
    logic [7:0]  lat;
    logic        full, lost;
    logic [4:0]  cnt;
    logic        req;
    logic [7:0]  bcid;
    logic [11:0] l1id;
  } vec_t;

  vec_t tbl [23];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_req(input int budget);
    int k = 0;
    while (req !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk("req_wait", {31'd0, req}, 32'd1);
  endtask

  task automatic ack_once();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          n  rst trg ack evr bcr lat  full lost cnt req bcid  l1id
    tbl[0]  = '{1,  1,  0,  0,  0,  0,  5,   0,   0,  0,  0,   0,   0};
    tbl[1]  = '{20, 0,  0,  0,  0,  0,  5,   0,   0,  0,  0,   0,   0};
    tbl[2]  = '{1,  0,  1,  0,  0,  0,  5,   0,   0,  1,  0,   0,   0};
    tbl[3]  = '{1,  0,  0,  0,  0,  0,  5,   0,   0,  1,  0,   0,   0};
    tbl[4]  = '{1,  0,  0,  0,  0,  0,  5,   0,   0,  1,  1,  15,   0};
    tbl[5]  = '{1,  0,  0,  1,  0,  0,  5,   0,   0,  0,  0,  15,   0};
    tbl[6]  = '{1,  0,  0,  0,  0,  0,  5,   0,   0,  0,  0,  15,   0};
    tbl[7]  = '{1,  0,  0,  0,  0,  1,  5,   0,   0,  0,  0,  15,   0};
    tbl[8]  = '{2,  0,  0,  0,  0,  0,  5,   0,   0,  0,  0,  15,   0};
    tbl[9]  = '{1,  0,  1,  0,  0,  0,  5,   0,   0,  1,  0,  15,   0};
    tbl[10] = '{2,  0,  0,  0,  0,  0,  5,   0,   0,  1,  1, 253,   1};
    tbl[11] = '{1,  0,  0,  1,  0,  0,  5,   0,   0,  0,  0, 253,   1};
    tbl[12] = '{1,  0,  0,  0,  0,  1,  0,   0,   0,  0,  0, 253,   1};
    tbl[13] = '{3,  0,  0,  0,  0,  0,  0,   0,   0,  0,  0, 253,   1};
    tbl[14] = '{1,  0,  1,  0,  0,  0,  0,   0,   0,  1,  0, 253,   1};
    tbl[15] = '{2,  0,  0,  0,  0,  0,  0,   0,   0,  1,  1,   3,   2};
    tbl[16] = '{1,  0,  0,  1,  0,  0,  0,   0,   0,  0,  0,   3,   2};
    tbl[17] = '{1,  0,  0,  0,  1,  0,  0,   0,   0,  0,  0,   3,   2};
    tbl[18] = '{15, 0,  1,  0,  0,  0,  0,   0,   0, 15,  1,   8,   0};
    tbl[19] = '{1,  0,  1,  0,  0,  0,  0,   1,   0, 16,  1,   8,   0};
    tbl[20] = '{1,  0,  1,  0,  0,  0,  0,   1,   1, 16,  1,   8,   0};
    tbl[21] = '{1,  0,  0,  0,  0,  0,  0,   1,   0, 16,  1,   8,   0};
    tbl[22] = '{1,  0,  1,  1,  0,  0,  0,   0,   1, 15,  0,   8,   0};

    for (int i = 0; i < 23; i++) begin
      rst = tbl[i].rst; trig = tbl[i].trig; ack = tbl[i].ack;
      evr = tbl[i].evr; bcr = tbl[i].bcr;   lat = tbl[i].lat;
      repeat (tbl[i].n) step();
      chk($sformatf("v%0d_full", i), {31'd0, full}, {31'd0, tbl[i].full});
      chk($sformatf("v%0d_lost", i), {31'd0, lost}, {31'd0, tbl[i].lost});
      chk($sformatf("v%0d_cnt", i),  {27'd0, cnt},  {27'd0, tbl[i].cnt});
      chk($sformatf("v%0d_req", i),  {31'd0, req},  {31'd0, tbl[i].req});
      chk($sformatf("v%0d_bcid", i), {24'd0, bcid}, {24'd0, tbl[i].bcid});
      chk($sformatf("v%0d_l1id", i), {20'd0, l1id}, {20'd0, tbl[i].l1id});
    end
    trig = 0; ack = 0; evr = 0; bcr = 0; rst = 0;

    // Drain the remaining 15 entries of the full register, in acceptance order.
    for (int i = 1; i < 16; i++) begin
      wait_req(10);
      chk("drain_l1id", {20'd0, l1id}, i);
      chk("drain_bcid", {24'd0, bcid}, 8 + i);
      ack_once();
    end
    chk("drain_cnt", {27'd0, cnt}, 0);

    trig = 1; step(); trig = 0;
    wait_req(10);
    chk("after_fill_l1id", {20'd0, l1id}, 16);
    ack_once();
    step();

    // Occupancy 3 with simultaneous trigger and ack.
    trig = 1; repeat (3) step(); trig = 0;
    chk("occ3_cnt", {27'd0, cnt}, 3);
    wait_req(10);
    chk("occ3_head", {20'd0, l1id}, 17);
    trig = 1; ack = 1; step(); trig = 0; ack = 0;
    chk("occ3_pushpop_cnt", {27'd0, cnt}, 3);
    chk("occ3_pushpop_lost", {31'd0, lost}, 0);
    for (int j = 0; j < 3; j++) begin
      wait_req(10);
      chk("occ3_drain_l1id", {20'd0, l1id}, 18 + j);
      ack_once();
    end
    step();

    // Ev_Reset during REQ with 4 pending and a simultaneous trigger.
    trig = 1; repeat (4) step(); trig = 0;
    wait_req(10);
    chk("evr_pre_cnt", {27'd0, cnt}, 4);
    evr = 1; trig = 1; step(); evr = 0; trig = 0;
    chk("evr_req", {31'd0, req}, 0);
    chk("evr_cnt", {27'd0, cnt}, 0);
    chk("evr_full", {31'd0, full}, 0);
    chk("evr_lost", {31'd0, lost}, 0);
    step();
    chk("evr_lost_next", {31'd0, lost}, 0);
    chk("evr_cnt_next", {27'd0, cnt}, 0);
    trig = 1; step(); trig = 0;
    wait_req(10);
    chk("evr_next_l1id", {20'd0, l1id}, 0);
    ack_once();
    step();

    // Reset mid-REQ with 5 pending, ack and trigger held during reset.
    trig = 1; repeat (5) step(); trig = 0;
    wait_req(10);
    chk("rst_pre_cnt", {27'd0, cnt}, 5);
    rst = 1; ack = 1; trig = 1; step(); trig = 0;
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_lost", {31'd0, lost}, 0);
    chk("rst_cnt", {27'd0, cnt}, 0);
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_bcid", {24'd0, bcid}, 0);
    chk("rst_l1id", {20'd0, l1id}, 0);
    rst = 0;
    repeat (4) step();
    ack = 0;
    chk("rst_after_cnt", {27'd0, cnt}, 0);
    chk("rst_after_req", {31'd0, req}, 0);
    trig = 1; step(); trig = 0;
    chk("rst_push_cnt", {27'd0, cnt}, 1);
    wait_req(10);
    chk("rst_next_l1id", {20'd0, l1id}, 0);
    ack_once();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/l1_trigger_scheduler.md
# l1_trigger_scheduler

Queues accepted Level-1 triggers from the trigger block and schedules their readout. Each accepted trigger is tagged with an L1 ID and the bunch-crossing ID it refers to, stored in a bounded pending-trigger register, and presented one at a time to the end-of-chip readout over a request/acknowledge handshake. The block drives `L1_Reg_Full` back to the trigger block so triggers are blocked at the source while the register is full.

## Interface

Parameters:
- `DEPTH`, 16: pending-trigger entries; power of two, 2..64.
- `BCID_W`, 8: bunch-crossing counter width.
- `L1ID_W`, 12: L1 ID counter width.

Ports:
- `Clk`  in  1  single clock; all logic on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `L1Trig_In`  in  1  trigger, one pulse per clock per trigger (multi-cycle = multiple triggers).
- `Bc_Reset`  in  1  clears BCID counter.
- `Ev_Reset`  in  1  flushes queue, clears L1 ID counter.
- `Latency`  in  8  trigger latency in clocks; must be < 2^BCID_W.
- `L1_Reg_Full`  out  1  pending register full.
- `Trig_Lost`  out  1  one-cycle pulse: trigger arrived while full.
- `Pending_Count`  out  log2(DEPTH)+1  current occupancy.
- `Rd_Req`  out  1  readout request.
- `Rd_Bcid`  out  BCID_W  BCID of presented trigger.
- `Rd_L1id`  out  L1ID_W  L1 ID of presented trigger.
- `Rd_Ack`  in  1  readout accepted the presented entry.

## Operation

- BCID counter: increments every clock, wraps modulo 2^BCID_W; `Bc_Reset` loads 0 (counter reads 0 after that edge).
- Accept: `L1Trig_In`=1 and `L1_Reg_Full`=0 at an edge → push {BCID counter − `Latency` mod 2^BCID_W, L1 ID counter}; L1 ID counter increments, wraps modulo 2^L1ID_W.
- Reject: `L1Trig_In`=1 and `L1_Reg_Full`=1 → no push, no L1 ID increment, `Trig_Lost`=1 for one cycle. This holds even when a pop occurs at the same edge.
- Push and pop at the same edge while not full: both happen, occupancy unchanged.
- `L1_Reg_Full` = (`Pending_Count` == DEPTH). Registered, updated at the same edge as occupancy.
- Readout FSM:
  - IDLE: occupancy ≠ 0 → LOAD.
  - LOAD: copy head entry into `Rd_Bcid`/`Rd_L1id` → REQ.
  - REQ: `Rd_Req`=1. When `Rd_Ack`=1, pop the head and go to GAP.
  - GAP: `Rd_Req`=0. Occupancy ≠ 0 → LOAD, else → IDLE.
- `Rd_Bcid`/`Rd_L1id` hold their value from LOAD until the next LOAD. They are stable throughout REQ.
- `Rd_Ack` is ignored outside REQ.
- Entries are delivered strictly in order of acceptance.
- `Ev_Reset`:
  - Occupancy → 0, L1 ID counter → 0, FSM → IDLE, `Rd_Req` → 0.
  - A simultaneous `L1Trig_In` is discarded without `Trig_Lost`.
  - `Rd_Ack` at the same edge has no further effect.
  - BCID counter is not affected.
- `Reset`: all state cleared.
  - Outputs after reset: `L1_Reg_Full`=0, `Trig_Lost`=0, `Pending_Count`=0, `Rd_Req`=0, `Rd_Bcid`=0, `Rd_L1id`=0.
  - BCID and L1 ID counters = 0, FSM = IDLE.
  - `Reset` overrides every other input.

## Timing

- Empty queue, FSM in IDLE, trigger sampled at edge k:
  - `Pending_Count`=1 from k.
  - LOAD after k+1.
  - `Rd_Req`=1 with valid data from edge k+2.
- `Rd_Ack` sampled at edge m in REQ:
  - Pop at m; `Rd_Req`=0 from m.
  - If entries remain: LOAD after m+1, next `Rd_Req`=1 from m+2.
  - Minimum 3 clocks per trigger.
- `L1_Reg_Full` rises at the edge of the DEPTH-th accepted push. It falls at the edge of the first pop.
- `Trig_Lost` is high in the cycle after the rejecting edge.
- `Ev_Reset` at edge e: `Pending_Count`=0, `L1_Reg_Full`=0 and `Rd_Req`=0 from e.

## Test plan

- Reset; `Latency`=5; single trigger when BCID counter=20 → `Rd_Req`=1 two edges later, `Rd_Bcid`=15, `Rd_L1id`=0. Ack → `Pending_Count`=0, FSM returns to IDLE, `Rd_Req`=0.
- Latency wrap: `Latency`=5, trigger at BCID=2 → `Rd_Bcid`=253 (BCID_W=8). `Bc_Reset` then trigger 3 clocks later with `Latency`=0 → `Rd_Bcid`=3.
- Fill (DEPTH=16): 17 consecutive trigger cycles, no ack.
  - `L1_Reg_Full`=1 after the 16th.
  - 17th → `Trig_Lost` pulse, `Pending_Count`=16.
  - Acking all entries yields L1 IDs 0..15 in order.
  - The next accepted trigger gets L1 ID 16.
- Simultaneous events:
  - Occupancy 3, trigger and ack at the same edge → `Pending_Count` stays 3.
  - Occupancy 16, trigger and ack at the same edge → trigger lost, `Pending_Count`=15, `L1_Reg_Full`=0.
- `Ev_Reset` during REQ with 4 pending plus a simultaneous trigger → `Rd_Req`=0, `Pending_Count`=0, no `Trig_Lost`. Next trigger → `Rd_L1id`=0.
- `Reset` asserted mid-REQ with 5 pending → all outputs at reset values after the edge. `Rd_Ack` held high during reset causes no pop afterward.
